// File: rtl/tpu_pkg.sv
// tpu_pkg: shared state type, default sizes and counter sizing
// for the N x N systolic tile feeder.
package tpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_SETTLE,
    ST_DRAIN,
    ST_CLEAR
  } feeder_state_t;

  localparam int TPU_N    = 2;
  localparam int TPU_DW   = 8;
  localparam int TPU_ACCW = 12;
  localparam int TPU_OUTW = 8;

  function automatic int cnt_width(input int n, input int settle);
    int m;
    m = 2 * n - 1;
    if (settle > m) m = settle;
    if (n * n > m) m = n * n;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mmu_feeder_nxn_sat_narrow.sv
// sat_narrow: signed accumulator to host-width narrowing.
// MMU_FEEDER_SAT_EN selects saturation; otherwise plain wrap.
module sat_narrow #(
  parameter int IW = 12,
  parameter int OW = 8
) (
  input  logic signed [IW-1:0] value,
  output logic        [OW-1:0] narrowed
);

`ifdef MMU_FEEDER_SAT_EN
  localparam logic signed [IW-1:0] MAXV =
    {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV =
    {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    narrowed = value[OW-1:0];
    if (value > MAXV)
      narrowed = {1'b0, {(OW-1){1'b1}}};
    else if (value < MINV)
      narrowed = {1'b1, {(OW-1){1'b0}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^value[IW-1:OW];
  assign narrowed  = value[OW-1:0];
`endif

endmodule

// File: rtl/mmu_feeder_nxn.sv
// mmu_feeder_nxn: skewed tile feed into an N x N array, then drain.
// Define MMU_FEEDER_SAT_EN for saturating output narrowing.
module mmu_feeder_nxn
  import tpu_pkg::*;
#(
  parameter int N      = TPU_N,
  parameter int DW     = TPU_DW,
  parameter int ACCW   = TPU_ACCW,
  parameter int OUTW   = TPU_OUTW,
  parameter int SETTLE = N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              transpose,
  input  logic [N*N*DW-1:0] weight_flat,
  input  logic [N*N*DW-1:0] input_flat,
  input  logic [N*N*ACCW-1:0] c_flat,
  output logic [N*DW-1:0]   a_data,
  output logic [N*DW-1:0]   b_data,
  output logic              clear,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUTW-1:0]   out_data,
  output logic              out_last
);

  localparam int CW = cnt_width(N, SETTLE);
  localparam logic [CW-1:0] T_LAST = CW'(2 * N - 2);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] K_LAST = CW'(N * N - 1);

  feeder_state_t state;
  logic [CW-1:0] t;
  logic [CW-1:0] s;
  logic [CW-1:0] k;
  logic [N*N*DW-1:0] w_q;
  logic [N*N*DW-1:0] x_q;
  logic tr_q;

  logic [N*N*DW-1:0] w_src;
  logic [N*N*DW-1:0] x_src;
  logic tr_src;
  logic [N*DW-1:0] a_nxt;
  logic [N*DW-1:0] b_nxt;
  int step;
  int d;

  logic [CW-1:0] k_nxt;
  logic signed [ACCW-1:0] c_sel;
  logic [OUTW-1:0] c_nar;

  assign busy = (state != ST_IDLE);

  // Step 0 is built from the live inputs so it lands on the
  // same edge that captures the tiles.
  always_comb begin
    w_src  = (state == ST_IDLE) ? weight_flat : w_q;
    x_src  = (state == ST_IDLE) ? input_flat : x_q;
    tr_src = (state == ST_IDLE) ? transpose : tr_q;
    step   = (state == ST_IDLE) ? 0 : int'(t) + 1;
    a_nxt  = '0;
    b_nxt  = '0;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = step - i;
      if (d >= 0 && d < N) begin
        a_nxt[i*DW +: DW] = w_src[(i*N+d)*DW +: DW];
        if (tr_src)
          b_nxt[i*DW +: DW] = x_src[(i*N+d)*DW +: DW];
        else
          b_nxt[i*DW +: DW] = x_src[(d*N+i)*DW +: DW];
      end
    end
  end

  always_comb begin
    k_nxt = '0;
    if (state == ST_DRAIN && k != K_LAST)
      k_nxt = k + CW'(1);
    c_sel = c_flat[int'(k_nxt)*ACCW +: ACCW];
  end

  sat_narrow #(
    .IW(ACCW),
    .OW(OUTW)
  ) u_narrow (
    .value   (c_sel),
    .narrowed(c_nar)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      t         <= '0;
      s         <= '0;
      k         <= '0;
      w_q       <= '0;
      x_q       <= '0;
      tr_q      <= 1'b0;
      a_data    <= '0;
      b_data    <= '0;
      clear     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      clear <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            w_q    <= weight_flat;
            x_q    <= input_flat;
            tr_q   <= transpose;
            t      <= '0;
            a_data <= a_nxt;
            b_data <= b_nxt;
            state  <= ST_FEED;
          end
        end
        ST_FEED: begin
          a_data <= a_nxt;
          b_data <= b_nxt;
          if (t == T_LAST) begin
            s     <= '0;
            state <= ST_SETTLE;
          end else begin
            t <= t + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (s == S_LAST) begin
            k         <= '0;
            out_data  <= c_nar;
            out_valid <= 1'b1;
            out_last  <= (k_nxt == K_LAST);
            state     <= ST_DRAIN;
          end else begin
            s <= s + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (k == K_LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              clear     <= 1'b1;
              state     <= ST_CLEAR;
            end else begin
              k        <= k_nxt;
              out_data <= c_nar;
              out_last <= (k_nxt == K_LAST);
            end
          end
        end
        ST_CLEAR: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_feeder_nxn.sv
// tb_mmu_feeder_nxn: timeline model of the feeder checked every
// cycle against an N=2 and an N=4 instance.
module tb_mmu_feeder_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst2, start2, tr2, clr2, busy2, ov2, rdy2, ol2;
  logic [31:0]  w2, x2;
  logic [47:0]  c2;
  logic [15:0]  a2, b2;
  logic [7:0]   od2;

  logic         rst4, start4, tr4, clr4, busy4, ov4, rdy4, ol4;
  logic [127:0] w4, x4;
  logic [191:0] c4;
  logic [31:0]  a4, b4;
  logic [7:0]   od4;

  mmu_feeder_nxn #(
    .N(2), .DW(8), .ACCW(12), .OUTW(8), .SETTLE(2)
  ) u2 (
    .clk(clk), .rst(rst2), .start(start2), .transpose(tr2),
    .weight_flat(w2), .input_flat(x2), .c_flat(c2),
    .a_data(a2), .b_data(b2), .clear(clr2), .busy(busy2),
    .out_valid(ov2), .out_ready(rdy2), .out_data(od2),
    .out_last(ol2)
  );

  mmu_feeder_nxn #(
    .N(4), .DW(8), .ACCW(12), .OUTW(8), .SETTLE(4)
  ) u4 (
    .clk(clk), .rst(rst4), .start(start4), .transpose(tr4),
    .weight_flat(w4), .input_flat(x4), .c_flat(c4),
    .a_data(a4), .b_data(b4), .clear(clr4), .busy(busy4),
    .out_valid(ov4), .out_ready(rdy4), .out_data(od4),
    .out_last(ol4)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int mn[2]  = '{2, 4};
  int mst[2] = '{2, 4};
  int tw[2][16], tx[2][16], tc[2][16];
  bit ttr[2];
  int mw[2][16], mx[2][16], mc[2][16];
  bit mtr[2];
  int mcyc[2] = '{0, 0};
  int mdc[2]  = '{0, 0};

  int sa[2][4], sb[2][4], sod[2];
  bit sbusy[2], sclr[2], sov[2], sol[2];
  bit srst[2], sst[2], srdy[2];

  int got[$];

  task automatic cmp(input string nm, input int u,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s u%0d t=%0t got %0h want %0h",
               nm, u, $time, act, exp);
    end
  endtask

  function automatic int narrow(input int v);
    int r;
    r = v;
`ifdef MMU_FEEDER_SAT_EN
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
`endif
    return r & 255;
  endfunction

  // cycle 1 is the first FEED cycle after an accepted start
  task automatic check_unit(input int u);
    int n, s, c, step, d;
    int ea[4], eb[4];
    bit e_busy, e_clr, e_ov, e_ol;
    int e_od;
    n = mn[u]; s = mst[u]; c = mcyc[u];
    e_busy = 0; e_clr = 0; e_ov = 0; e_ol = 0; e_od = 0;
    for (int i = 0; i < 4; i++) begin ea[i] = 0; eb[i] = 0; end
    if (c > 0) begin
      e_busy = 1;
      if (c <= 2 * n - 1) begin
        step = c - 1;
        for (int i = 0; i < n; i++) begin
          d = step - i;
          if (d >= 0 && d < n) begin
            ea[i] = mw[u][i*n+d];
            eb[i] = mtr[u] ? mx[u][i*n+d] : mx[u][d*n+i];
          end
        end
      end else if (c >= 2 * n + s) begin
        if (mdc[u] < n * n) begin
          e_ov = 1;
          e_od = narrow(mc[u][mdc[u]]);
          e_ol = (mdc[u] == n * n - 1);
        end else begin
          e_clr = 1;
        end
      end
    end
    cmp("busy", u, int'(sbusy[u]), int'(e_busy));
    cmp("clear", u, int'(sclr[u]), int'(e_clr));
    cmp("out_valid", u, int'(sov[u]), int'(e_ov));
    for (int i = 0; i < n; i++) begin
      cmp($sformatf("a_lane%0d", i), u, sa[u][i], ea[i]);
      cmp($sformatf("b_lane%0d", i), u, sb[u][i], eb[i]);
    end
    if (e_ov) begin
      cmp("out_data", u, sod[u], e_od);
      cmp("out_last", u, int'(sol[u]), int'(e_ol));
    end
    if (srst[u]) begin
      mcyc[u] = 0; mdc[u] = 0;
    end else if (c == 0) begin
      if (sst[u]) begin
        mcyc[u] = 1; mdc[u] = 0; mtr[u] = ttr[u];
        for (int i = 0; i < 16; i++) begin
          mw[u][i] = tw[u][i]; mx[u][i] = tx[u][i];
          mc[u][i] = tc[u][i];
        end
      end
    end else if (e_clr) begin
      mcyc[u] = 0;
    end else begin
      if (e_ov && srdy[u]) mdc[u]++;
      mcyc[u]++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        sa[0][i] = 0; sb[0][i] = 0;
        sa[1][i] = int'(a4[i*8 +: 8]);
        sb[1][i] = int'(b4[i*8 +: 8]);
      end
      for (int i = 0; i < 2; i++) begin
        sa[0][i] = int'(a2[i*8 +: 8]);
        sb[0][i] = int'(b2[i*8 +: 8]);
      end
      sbusy = '{busy2, busy4}; sclr = '{clr2, clr4};
      sov = '{ov2, ov4}; sol = '{ol2, ol4};
      sod = '{int'(od2), int'(od4)};
      srst = '{rst2, rst4}; sst = '{start2, start4};
      srdy = '{rdy2, rdy4};
      check_unit(0);
      check_unit(1);
    end
  end

  task automatic pack(input int u);
    for (int k = 0; k < mn[u] * mn[u]; k++) begin
      if (u == 0) begin
        w2[k*8 +: 8]  = 8'(tw[0][k]);
        x2[k*8 +: 8]  = 8'(tx[0][k]);
        c2[k*12 +: 12] = 12'(tc[0][k]);
        tr2 = ttr[0];
      end else begin
        w4[k*8 +: 8]  = 8'(tw[1][k]);
        x4[k*8 +: 8]  = 8'(tx[1][k]);
        c4[k*12 +: 12] = 12'(tc[1][k]);
        tr4 = ttr[1];
      end
    end
  endtask

  task automatic rand_tiles(input int u);
    for (int k = 0; k < 16; k++) begin
      tw[u][k] = int'($urandom_range(255));
      tx[u][k] = int'($urandom_range(255));
      tc[u][k] = int'($urandom_range(4095)) - 2048;
    end
    ttr[u] = 1'($urandom_range(1));
    pack(u);
  endtask

  logic [15:0] a_lit[3], bn_lit[3], bt_lit[3];
  int od_lit[4];

  task automatic run2(input bit lit, input bit bp, input int rst_at,
                      output int first, output int clr_at,
                      output int idle_at, output int clr_cnt);
    int cyc;
    first = -1; clr_at = -1; idle_at = -1; clr_cnt = 0;
    got.delete();
    @(posedge clk); #1;
    start2 = 1'b1; rdy2 = 1'b1; cyc = 0;
    while (cyc < 16) begin
      @(negedge clk);
      if (lit && cyc >= 1 && cyc <= 3) begin
        cmp("lit_a", 0, int'(a2), int'(a_lit[cyc-1]));
        cmp("lit_b", 0, int'(b2),
            ttr[0] ? int'(bt_lit[cyc-1]) : int'(bn_lit[cyc-1]));
      end
      if (ov2 && first < 0) first = cyc;
      if (clr2) begin
        clr_cnt++;
        if (clr_at < 0) clr_at = cyc;
      end
      if (cyc > 0 && !busy2 && idle_at < 0) idle_at = cyc;
      if (ov2 && rdy2 && !rst2) got.push_back(int'(od2));
      @(posedge clk); #1;
      cyc++;
      start2 = 1'b0;
      rdy2 = !(bp && cyc >= 7 && cyc <= 9);
      rst2 = (cyc == rst_at);
    end
    rst2 = 1'b0; rdy2 = 1'b1;
  endtask

  task automatic run4(input bit rnd, output int n_acc,
                      output int clr_cnt, output int idle_at);
    int cyc;
    n_acc = 0; clr_cnt = 0; idle_at = -1;
    rand_tiles(1);
    @(posedge clk); #1;
    start4 = 1'b1; rdy4 = 1'b1; cyc = 0;
    while (cyc < 150 && idle_at < 0) begin
      @(negedge clk);
      if (clr4) clr_cnt++;
      if (cyc > 0 && !busy4) idle_at = cyc;
      if (ov4 && rdy4) n_acc++;
      @(posedge clk); #1;
      cyc++;
      start4 = (cyc == 3);
      rdy4 = rnd ? 1'($urandom_range(1)) : 1'b1;
    end
    start4 = 1'b0; rdy4 = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int first, clr_at, idle_at, clr_cnt, n_acc;
    a_lit  = '{16'h0001, 16'h0302, 16'h0400};
    bn_lit = '{16'h0005, 16'h0607, 16'h0800};
    bt_lit = '{16'h0005, 16'h0706, 16'h0800};
`ifdef MMU_FEEDER_SAT_EN
    od_lit = '{'h7F, 'h80, 'h05, 'hFF};
`else
    od_lit = '{'hC8, 'hD4, 'h05, 'hFF};
`endif
    rst2 = 1; start2 = 0; tr2 = 0; rdy2 = 1;
    w2 = '0; x2 = '0; c2 = '0;
    rst4 = 1; start4 = 0; tr4 = 0; rdy4 = 1;
    w4 = '0; x4 = '0; c4 = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst2 = 0; rst4 = 0;
    @(negedge clk);
    cmp("rst_a", 0, int'(a2), 0);
    cmp("rst_busy", 0, int'(busy2), 0);
    cmp("rst_valid", 0, int'(ov2), 0);
    cmp("rst_data", 0, int'(od2), 0);
    cmp("rst_last", 0, int'(ol2), 0);
    cmp("rst_clear", 0, int'(clr2), 0);
    cmp("rst_data", 1, int'(od4), 0);
    cmp("rst_b", 1, int'(b4), 0);

    for (int k = 0; k < 4; k++) begin
      tw[0][k] = k + 1; tx[0][k] = k + 5;
    end
    tc[0][0] = 200; tc[0][1] = -300; tc[0][2] = 5; tc[0][3] = -1;
    ttr[0] = 0; pack(0);
    run2(1, 0, -1, first, clr_at, idle_at, clr_cnt);
    cmp("first_valid", 0, first, 6);
    cmp("clear_cycle", 0, clr_at, 10);
    cmp("idle_cycle", 0, idle_at, 11);
    cmp("clear_count", 0, clr_cnt, 1);
    cmp("n_accept", 0, got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      cmp("lit_od", 0, got[i], od_lit[i]);

    ttr[0] = 1; pack(0);
    run2(1, 1, -1, first, clr_at, idle_at, clr_cnt);
    cmp("bp_idle_cycle", 0, idle_at, 14);
    cmp("bp_clear_count", 0, clr_cnt, 1);
    cmp("bp_n_accept", 0, got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      cmp("bp_od", 0, got[i], od_lit[i]);

    run2(0, 0, 8, first, clr_at, idle_at, clr_cnt);
    cmp("rst_idle_cycle", 0, idle_at, 9);
    cmp("rst_no_clear", 0, clr_cnt, 0);

    rand_tiles(0);
    run2(0, 0, -1, first, clr_at, idle_at, clr_cnt);
    cmp("fresh_idle_cycle", 0, idle_at, 11);
    cmp("fresh_n_accept", 0, got.size(), 4);
    cmp("fresh_clear_count", 0, clr_cnt, 1);

    run4(0, n_acc, clr_cnt, idle_at);
    cmp("n4_idle_cycle", 1, idle_at, 29);
    cmp("n4_n_accept", 1, n_acc, 16);
    cmp("n4_clear_count", 1, clr_cnt, 1);

    for (int r = 0; r < 3; r++) begin
      run4(1, n_acc, clr_cnt, idle_at);
      cmp("n4r_done", 1, int'(idle_at > 0), 1);
      cmp("n4r_n_accept", 1, n_acc, 16);
      cmp("n4r_clear_count", 1, clr_cnt, 1);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
